// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter_if                                         |
// | Description : Bundle between two byte requesters, the baud-tick          |
// |               generator and the shared UART transmitter.                 |
// |               master : application side (requesters + tick generator)    |
// |               slave  : uart_tx_arbiter                                   |
// | Signals     : req0/data0/gnt0, req1/data1/gnt1  requester handshakes     |
// |               bps_en/bps_clk                    baud generator control   |
// |               tx_out, busy, done                line and frame status    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface uart_tx_arbiter_if;
   logic       req0;
   logic [7:0] data0;
   logic       gnt0;
   logic       req1;
   logic [7:0] data1;
   logic       gnt1;
   logic       bps_en;
   logic       bps_clk;
   logic       tx_out;
   logic       busy;
   logic       done;

   modport master (
      output req0, data0, req1, data1, bps_clk,
      input  gnt0, gnt1, bps_en, tx_out, busy, done
   );

   modport slave (
      input  req0, data0, req1, data1, bps_clk,
      output gnt0, gnt1, bps_en, tx_out, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Round-robin arbiter sharing one UART 8N1/8N2 transmitter   |
// |               between two byte requesters. Drives bps_en for one frame   |
// |               and advances one bit per bps_clk tick.                     |
// | Ports       : clk_in    system clock                                     |
// |               rst_n_in  asynchronous active-low reset                    |
// |               bus       uart_tx_arbiter_if.slave (requests, grants,      |
// |                         baud control, tx line, busy/done status)         |
// | Parameters  : STOP_BITS  1 or 2 stop bits per frame                      |
// |               FIRST_PRIO requester winning the first tie after reset     |
// | Options     : UART_TX_PARITY_EN  adds an even-parity bit after the data  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int STOP_BITS  = 1,
   parameter int FIRST_PRIO = 0
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   uart_tx_arbiter_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Tick number carrying the first stop bit; the frame completes after the
   // last stop bit has been on the line for one full bit period.
`ifdef UART_TX_PARITY_EN
   localparam int STOP_TICK = 11;
`else
   localparam int STOP_TICK = 10;
`endif
   localparam logic [3:0] LAST_TICK = 4'(STOP_TICK + STOP_BITS);

   // The pointer holds the last granted requester, so the reset value is the
   // opposite of the one that should win the first tie.
   localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

   state_t     state_q,   state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q,   shift_d;
   logic       last_q,    last_d;
   logic       gnt0_q,    gnt0_d;
   logic       gnt1_q,    gnt1_d;
   logic       bps_en_q,  bps_en_d;
   logic       tx_out_q,  tx_out_d;
   logic       busy_q,    busy_d;
   logic       done_q,    done_d;
`ifdef UART_TX_PARITY_EN
   logic       parity_q,  parity_d;
`endif

   logic       pick1;
   logic [7:0] sel_byte;
   logic [3:0] tick_cnt;

   // Requester 1 wins when it is alone, or on a tie when 0 was served last.
   assign pick1    = bus.req1 & (~bus.req0 | ~last_q);
   assign sel_byte = pick1 ? bus.data1 : bus.data0;
   assign tick_cnt = bit_cnt_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      last_d    = last_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      bps_en_d  = bps_en_q;
      tx_out_d  = tx_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            // Any bps_clk seen here is stale and ignored.
            if (bus.req0 | bus.req1) begin
               gnt0_d    = ~pick1;
               gnt1_d    = pick1;
               last_d    = pick1;
               shift_d   = sel_byte;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^sel_byte;
`endif
               bps_en_d  = 1'b1;
               busy_d    = 1'b1;
               bit_cnt_d = 4'd0;
               state_d   = SEND;
            end
         end

         SEND: begin
            if (bus.bps_clk) begin
               bit_cnt_d = tick_cnt;
               if (tick_cnt == 4'd1) begin
                  tx_out_d = 1'b0;
               end else if (tick_cnt <= 4'd9) begin
                  // Data leaves LSB first straight out of the shifter.
                  tx_out_d = shift_q[0];
                  shift_d  = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
               end else if (tick_cnt == 4'd10) begin
                  tx_out_d = parity_q;
`endif
               end else begin
                  tx_out_d = 1'b1;
               end

               if (tick_cnt == LAST_TICK) begin
                  tx_out_d = 1'b1;
                  bps_en_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= 8'd0;
         last_q    <= LAST_RST;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         bps_en_q  <= 1'b0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         last_q    <= last_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         bps_en_q  <= bps_en_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign bus.gnt0   = gnt0_q;
   assign bus.gnt1   = gnt1_q;
   assign bus.bps_en = bps_en_q;
   assign bus.tx_out = tx_out_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Bench for uart_tx_arbiter. Two instances (8N1 with         |
// |               requester 0 first, 8N2 with requester 1 first), each with  |
// |               a 16-clock baud-tick generator. Stimulus pushes expected   |
// |               frames; a monitor rebuilds frames from the line and pops.  |
// | Options     : UART_TX_PARITY_EN  expected frames carry the parity bit    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;
   always #5 clk_in = ~clk_in;

   uart_tx_arbiter_if bus_a ();
   uart_tx_arbiter_if bus_b ();

   uart_tx_arbiter #(.STOP_BITS(1), .FIRST_PRIO(0)) dut_a (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus_a)
   );

   uart_tx_arbiter #(.STOP_BITS(2), .FIRST_PRIO(1)) dut_b (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus_b)
   );

   // Baud-tick generators: BPS_PARA=16, mid-bit tick half a period after enable.
   logic [3:0] div_a, div_b;
   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in || !bus_a.bps_en) begin
         div_a <= 4'd0; bus_a.bps_clk <= 1'b0;
      end else begin
         div_a <= div_a + 4'd1; bus_a.bps_clk <= (div_a == 4'd7);
      end
   end
   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in || !bus_b.bps_en) begin
         div_b <= 4'd0; bus_b.bps_clk <= 1'b0;
      end else begin
         div_b <= div_b + 4'd1; bus_b.bps_clk <= (div_b == 4'd7);
      end
   end

`ifdef UART_TX_PARITY_EN
   localparam int PAR_TICKS = 1;
`else
   localparam int PAR_TICKS = 0;
`endif

   typedef struct packed {
      logic        who;
      logic [15:0] bits;   // bit i = line value after tick i+1
      logic [4:0]  nt;     // tick on which done must appear
   } exp_t;

   exp_t sb [2][16];
   int   wp [2] = '{0, 0};
   int   rp [2] = '{0, 0};

   int   n_vec     = 0;
   int   n_miss    = 0;
   int   n_timeout = 0;
   logic fin_req   = 1'b0;
   logic fin_ack   = 1'b0;

   // Start bit, data LSB first, optional even parity, stop/idle ones.
   function automatic logic [15:0] frame_bits(input logic [7:0] b);
      logic [15:0] f;
      f      = 16'hFFFF;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   task automatic push(input int k, input logic who, input logic [7:0] b);
      exp_t e;
      e.who  = who;
      e.bits = frame_bits(b);
      e.nt   = 5'(10 + PAR_TICKS + ((k == 0) ? 1 : 2));
      sb[k][wp[k] % 16] = e;
      wp[k]++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor state per instance.
   logic        in_fr    [2];
   logic        who_r    [2];
   logic [15:0] rec      [2];
   int          nt_r     [2];
   logic        tick_p   [2];
   logic        pre_ok   [2];
   logic        lat_pend [2];

   task automatic mon_step(input int k, input logic g0, input logic g1, input logic bps,
                           input logic busy, input logic tx, input logic done,
                           input logic en, input logic r0, input logic r1);
      string p;
      exp_t  e;
      p = (k == 0) ? "a" : "b";
      if (lat_pend[k]) begin
         chk($sformatf("%s.grant_latency", p), 32'(g0 | g1), 32'd1);
         lat_pend[k] = 1'b0;
      end
      if (g0 | g1) begin
         chk($sformatf("%s.gnt_onehot", p), 32'(g0 & g1), 32'd0);
         chk($sformatf("%s.gnt_in_frame", p), 32'(in_fr[k]), 32'd0);
         in_fr[k]  = 1'b1;
         who_r[k]  = g1;
         rec[k]    = 16'hFFFF;
         nt_r[k]   = 0;
         pre_ok[k] = 1'b1;
      end else if (in_fr[k]) begin
         if (tick_p[k]) begin
            if (nt_r[k] < 16) rec[k][nt_r[k]] = tx;
            nt_r[k]++;
         end else if (nt_r[k] == 0 && tx !== 1'b1) begin
            pre_ok[k] = 1'b0;
         end
         if (done) begin
            chk($sformatf("%s.frame_expected", p), 32'(wp[k] != rp[k]), 32'd1);
            if (wp[k] != rp[k]) begin
               e = sb[k][rp[k] % 16];
               rp[k]++;
               chk($sformatf("%s.requester", p), 32'(who_r[k]), 32'(e.who));
               chk($sformatf("%s.done_tick", p), 32'(nt_r[k]), 32'(e.nt));
               chk($sformatf("%s.frame_bits", p), 32'(rec[k]), 32'(e.bits));
               chk($sformatf("%s.bps_en_at_done", p), 32'(en), 32'd0);
               chk($sformatf("%s.line_high_before_start", p), 32'(pre_ok[k]), 32'd1);
            end
            in_fr[k] = 1'b0;
         end
      end else if (done) begin
         chk($sformatf("%s.done_outside_frame", p), 32'(done), 32'd0);
      end
      tick_p[k]   = bps & busy;
      lat_pend[k] = ~busy & ~(g0 | g1) & (r0 | r1);
   endtask

   task automatic rst_chk(input int k, input logic tx, input logic en, input logic busy,
                          input logic g0, input logic g1, input logic done);
      string p;
      p = (k == 0) ? "a" : "b";
      chk($sformatf("%s.rst_tx_out", p), 32'(tx), 32'd1);
      chk($sformatf("%s.rst_bps_en", p), 32'(en), 32'd0);
      chk($sformatf("%s.rst_busy", p), 32'(busy), 32'd0);
      chk($sformatf("%s.rst_gnt", p), 32'({g1, g0}), 32'd0);
      chk($sformatf("%s.rst_done", p), 32'(done), 32'd0);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      for (int k = 0; k < 2; k++) begin
         in_fr[k] = 1'b0; who_r[k] = 1'b0; rec[k] = 16'hFFFF; nt_r[k] = 0;
         tick_p[k] = 1'b0; pre_ok[k] = 1'b1; lat_pend[k] = 1'b0;
      end
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            rst_chk(0, bus_a.tx_out, bus_a.bps_en, bus_a.busy, bus_a.gnt0, bus_a.gnt1, bus_a.done);
            rst_chk(1, bus_b.tx_out, bus_b.bps_en, bus_b.busy, bus_b.gnt0, bus_b.gnt1, bus_b.done);
            for (int k = 0; k < 2; k++) begin
               in_fr[k] = 1'b0; tick_p[k] = 1'b0; lat_pend[k] = 1'b0;
            end
         end else begin
            mon_step(0, bus_a.gnt0, bus_a.gnt1, bus_a.bps_clk, bus_a.busy, bus_a.tx_out,
                     bus_a.done, bus_a.bps_en, bus_a.req0, bus_a.req1);
            mon_step(1, bus_b.gnt0, bus_b.gnt1, bus_b.bps_clk, bus_b.busy, bus_b.tx_out,
                     bus_b.done, bus_b.bps_en, bus_b.req0, bus_b.req1);
            if (fin_req && !fin_ack) begin
               chk("wait_timeouts", 32'(n_timeout), 32'd0);
               for (int k = 0; k < 2; k++) begin
                  chk($sformatf("%s.frames_outstanding", (k == 0) ? "a" : "b"),
                      32'(wp[k] - rp[k]), 32'd0);
                  chk($sformatf("%s.frame_open_at_end", (k == 0) ? "a" : "b"),
                      32'(in_fr[k]), 32'd0);
               end
               fin_ack = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk_in);
      #1;
   endtask

   function automatic logic gnt_of(input int k, input logic which);
      if (k == 0) return which ? bus_a.gnt1 : bus_a.gnt0;
      return which ? bus_b.gnt1 : bus_b.gnt0;
   endfunction

   task automatic set_req(input int k, input logic which, input logic v, input logic [7:0] d);
      if (k == 0) begin
         if (which) begin bus_a.req1 = v; bus_a.data1 = d; end
         else       begin bus_a.req0 = v; bus_a.data0 = d; end
      end else begin
         if (which) begin bus_b.req1 = v; bus_b.data1 = d; end
         else       begin bus_b.req0 = v; bus_b.data0 = d; end
      end
   endtask

   task automatic wait_gnt(input int k, input logic which);
      int n;
      n = 0;
      while (!gnt_of(k, which) && n < 2000) begin step(); n++; end
      if (!gnt_of(k, which)) begin
         n_timeout++;
         $display("FAIL wait_gnt: instance %0d requester %0d got no grant, expected one", k, which);
      end
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while (((k == 0) ? bus_a.busy : bus_b.busy) && n < 2000) begin step(); n++; end
      if ((k == 0) ? bus_a.busy : bus_b.busy) begin
         n_timeout++;
         $display("FAIL wait_idle: instance %0d still busy, expected idle", k);
      end
      step();
   endtask

   task automatic single(input int k, input logic [7:0] b);
      push(k, 1'b0, b);
      set_req(k, 1'b0, 1'b1, b);
      wait_gnt(k, 1'b0);
      set_req(k, 1'b0, 1'b0, 8'h00);
      wait_idle(k);
   endtask

   task automatic tie(input int k, input logic first, input logic [7:0] b0, input logic [7:0] b1);
      push(k, first, first ? b1 : b0);
      push(k, ~first, first ? b0 : b1);
      set_req(k, 1'b0, 1'b1, b0);
      set_req(k, 1'b1, 1'b1, b1);
      wait_gnt(k, first);
      set_req(k, first, 1'b0, 8'h00);
      wait_gnt(k, ~first);
      set_req(k, ~first, 1'b0, 8'h00);
      wait_idle(k);
   endtask

   initial begin
      int n, cnt;
      bus_a.req0 = 1'b0; bus_a.data0 = 8'h00; bus_a.req1 = 1'b0; bus_a.data1 = 8'h00;
      bus_b.req0 = 1'b0; bus_b.data0 = 8'h00; bus_b.req1 = 1'b0; bus_b.data1 = 8'h00;
      repeat (4) step();
      rst_n_in = 1'b1;
      repeat (3) step();

      // First ties after reset: instance a serves 0 first, instance b serves 1 first.
      tie(0, 1'b0, 8'h11, 8'h22);
      tie(1, 1'b1, 8'h5A, 8'hC3);

      // Single frames, including all-ones with two stop bits.
      single(0, 8'hA5);
      single(0, 8'h07);
      single(1, 8'hFF);

      // Fairness: requester 0 keeps asking, requester 1 arrives mid-frame.
      push(0, 1'b0, 8'h31);
      push(0, 1'b1, 8'h41);
      push(0, 1'b0, 8'h32);
      set_req(0, 1'b0, 1'b1, 8'h31);
      wait_gnt(0, 1'b0);
      set_req(0, 1'b0, 1'b1, 8'h32);
      repeat (60) step();
      set_req(0, 1'b1, 1'b1, 8'h41);
      wait_gnt(0, 1'b1);
      set_req(0, 1'b1, 1'b0, 8'h00);
      wait_gnt(0, 1'b0);
      set_req(0, 1'b0, 1'b0, 8'h00);
      wait_idle(0);

      // Reset in the middle of a frame: nothing is expected for 0x3C.
      set_req(0, 1'b0, 1'b1, 8'h3C);
      wait_gnt(0, 1'b0);
      set_req(0, 1'b0, 1'b0, 8'h00);
      n = 0; cnt = 0;
      while (cnt < 5 && n < 2000) begin
         step(); n++;
         if (bus_a.bps_clk) cnt++;
      end
      if (cnt < 5) begin
         n_timeout++;
         $display("FAIL tick_wait: saw %0d ticks, expected 5", cnt);
      end
      @(posedge clk_in);
      #1 rst_n_in = 1'b0;
      @(negedge clk_in);
      #1 rst_n_in = 1'b1;
      repeat (40) step();

      // Pointer back at reset value: tie again goes to requester 0 first.
      tie(0, 1'b0, 8'h5C, 8'hE7);

      fin_req = 1'b1;
      n = 0;
      while (!fin_ack && n < 20) begin step(); n++; end
      if (!fin_ack) $display("FAIL final_check: monitor ack %0d, expected 1", fin_ack);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
